// File: rtl/eval_scheduler.sv
// eval_scheduler
//   Merges input-event arrivals and a periodic timebase into one FIFO of
//   evaluation requests. Each request is then stepped through the monitor's
//   evaluation layers, one layer per cycle. Every output is registered.
//
// Parameters
//   NUM_INPUTS    input streams
//   NUM_OUTPUTS   output streams, one pacing bit each
//   NUM_SLIDES    sliding windows
//   NUM_LAYERS    evaluation layers (1..4)
//   QUEUE_DEPTH   request FIFO entries (power of two)
//   PERIOD_CYCLES enabled cycles between periodic ticks (>= 2)
//   OUT_DEP       bit o*NUM_INPUTS+i set: output o is paced by input i
//   OUT_PERIODIC  bit o set: output o is paced by the periodic tick
//   OUT_LAYER     2 bits per output: evaluation layer of that output
//
// Ports
//   clk, rst      clock; synchronous active-high reset
//   en            global enable; when low all state holds and inputs are ignored
//   new_input     per-input arrival strobes
//   q_push        a push was attempted in the previous enabled cycle
//   q_push_valid  that push was accepted
//   q_pop         an entry was dequeued in the previous enabled cycle
//   q_pop_valid   the dequeued entry is valid
//   pacing        evaluate output o this cycle
//   slide         shift window w this cycle (layer 0 of periodic entries)
//   busy          scheduler is evaluating an entry
//   overflow      sticky; a push was rejected because the queue was full
//
// Build option
//   EVAL_SCHED_BYPASS_EN  when defined, a request that arrives while the
//                         scheduler is idle and the queue is empty skips the
//                         FIFO and starts evaluating on the next edge.

module eval_scheduler #(
  parameter int unsigned                          NUM_INPUTS    = 2,
  parameter int unsigned                          NUM_OUTPUTS   = 8,
  parameter int unsigned                          NUM_SLIDES    = 2,
  parameter int unsigned                          NUM_LAYERS    = 3,
  parameter int unsigned                          QUEUE_DEPTH   = 4,
  parameter int unsigned                          PERIOD_CYCLES = 500,
  parameter logic [NUM_OUTPUTS*NUM_INPUTS-1:0]    OUT_DEP       = '0,
  parameter logic [NUM_OUTPUTS-1:0]               OUT_PERIODIC  = '0,
  parameter logic [2*NUM_OUTPUTS-1:0]             OUT_LAYER     = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [NUM_INPUTS-1:0]  new_input,
  output logic                   q_push,
  output logic                   q_push_valid,
  output logic                   q_pop,
  output logic                   q_pop_valid,
  output logic [NUM_OUTPUTS-1:0] pacing,
  output logic [NUM_SLIDES-1:0]  slide,
  output logic                   busy,
  output logic                   overflow
);

  // Entry layout: {periodic, input_mask}
  localparam int unsigned EW = NUM_INPUTS + 1;
  localparam int unsigned AW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CW = $clog2(QUEUE_DEPTH + 1);
  localparam int unsigned TW = $clog2(PERIOD_CYCLES);
  localparam logic [1:0]  LAST_LAYER = 2'(NUM_LAYERS - 1);
  localparam logic [AW-1:0] LAST_SLOT = AW'(QUEUE_DEPTH - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(QUEUE_DEPTH);
  localparam logic [TW-1:0] LAST_TICK = TW'(PERIOD_CYCLES - 1);

  typedef enum logic {
    IDLE,
    EVAL
  } state_t;

  state_t        state;
  logic [1:0]    layer;
  logic [EW-1:0] cur_entry;

  logic [EW-1:0] mem [QUEUE_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [TW-1:0] tick_cnt;

  logic          tick;
  logic          req;
  logic          q_empty;
  logic          q_full;
  logic          pop;
  logic          bypass;
  logic          push_try;
  logic          push_ok;
  logic          start;
  logic [EW-1:0] req_entry;
  logic [EW-1:0] start_entry;

  // Pacing vector for one layer of one entry.
  function automatic logic [NUM_OUTPUTS-1:0] pace_for(input logic [EW-1:0] entry,
                                                      input logic [1:0]    lyr);
    logic [NUM_OUTPUTS-1:0] res;
    res = '0;
    for (int unsigned o = 0; o < NUM_OUTPUTS; o++) begin
      res[o] = (OUT_LAYER[2*o +: 2] == lyr) &&
               ((|(OUT_DEP[o*NUM_INPUTS +: NUM_INPUTS] & entry[NUM_INPUTS-1:0])) ||
                (OUT_PERIODIC[o] && entry[NUM_INPUTS]));
    end
    return res;
  endfunction

  always_comb begin
    tick      = (tick_cnt == LAST_TICK);
    req       = en && ((|new_input) || tick);
    req_entry = {tick, new_input};
    q_empty   = (count == '0);
    q_full    = (count == FULL_COUNT);
    pop       = en && (state == IDLE) && !q_empty;
`ifdef EVAL_SCHED_BYPASS_EN
    bypass    = req && (state == IDLE) && q_empty;
`else
    bypass    = 1'b0;
`endif
    push_try  = req && !bypass;
    // A pop on the same edge frees a slot, so a full queue still accepts.
    push_ok   = push_try && (!q_full || pop);
    start     = pop || bypass;
    start_entry = bypass ? req_entry : mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      layer        <= '0;
      cur_entry    <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      tick_cnt     <= '0;
      q_push       <= 1'b0;
      q_push_valid <= 1'b0;
      q_pop        <= 1'b0;
      q_pop_valid  <= 1'b0;
      pacing       <= '0;
      slide        <= '0;
      busy         <= 1'b0;
      overflow     <= 1'b0;
    end else if (en) begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;

      q_push       <= req;
      q_push_valid <= push_ok || bypass;
      q_pop        <= start;
      q_pop_valid  <= start;

      if (push_try && !push_ok) begin
        overflow <= 1'b1;
      end

      if (push_ok) begin
        wr_ptr <= (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_SLOT) ? '0 : rd_ptr + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase

      case (state)
        IDLE: begin
          if (start) begin
            state     <= EVAL;
            layer     <= '0;
            cur_entry <= start_entry;
            pacing    <= pace_for(start_entry, 2'd0);
            slide     <= {NUM_SLIDES{start_entry[NUM_INPUTS]}};
            busy      <= 1'b1;
          end else begin
            pacing <= '0;
            slide  <= '0;
            busy   <= 1'b0;
          end
        end
        EVAL: begin
          slide <= '0;
          if (layer == LAST_LAYER) begin
            state  <= IDLE;
            pacing <= '0;
            busy   <= 1'b0;
          end else begin
            layer  <= layer + 2'd1;
            pacing <= pace_for(cur_entry, layer + 2'd1);
            busy   <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          pacing <= '0;
          slide  <= '0;
          busy   <= 1'b0;
        end
      endcase
    end else begin
      // Disabled: everything holds except the one-cycle queue strobes.
      q_push <= 1'b0;
      q_pop  <= 1'b0;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (en && push_ok) begin
      mem[wr_ptr] <= req_entry;
    end
  end

endmodule

// File: tb/tb_eval_scheduler.sv
// tb_eval_scheduler
//   Randomised scoreboard bench for eval_scheduler. The stimulus process runs
//   a queue-based reference model and pushes expected push/pop responses,
//   tagged with the enabled-cycle index they belong to; the monitor samples
//   on the falling edge and checks the DUT against them.

module tb_eval_scheduler;

  localparam int NI     = 2;
  localparam int NO     = 8;
  localparam int NS     = 2;
  localparam int NL     = 3;
  localparam int DEPTH  = 4;
  localparam int PERIOD = 500;

  // Output map: in0 -> o1,o2 ; in1 -> o3,o5,o6,o7 ; tick -> o0,o6
  // Layers: o2,o5 = 2 ; o3,o6 = 1 ; others 0
  localparam logic [NO*NI-1:0] P_DEP      = 16'hA894;
  localparam logic [NO-1:0]    P_PERIODIC = 8'h41;
  localparam logic [2*NO-1:0]  P_LAYER    = 16'h1860;

  int layer_of [8] = '{0, 0, 2, 1, 0, 2, 1, 0};
  bit by_in0   [8] = '{0, 1, 1, 0, 0, 0, 0, 0};
  bit by_in1   [8] = '{0, 0, 0, 1, 0, 1, 1, 1};
  bit by_tick  [8] = '{1, 0, 0, 0, 0, 0, 1, 0};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [NI-1:0] new_input = '0;
  logic          q_push, q_push_valid, q_pop, q_pop_valid, busy, overflow;
  logic [NO-1:0] pacing;
  logic [NS-1:0] slide;

  eval_scheduler #(
    .NUM_INPUTS   (NI),
    .NUM_OUTPUTS  (NO),
    .NUM_SLIDES   (NS),
    .NUM_LAYERS   (NL),
    .QUEUE_DEPTH  (DEPTH),
    .PERIOD_CYCLES(PERIOD),
    .OUT_DEP      (P_DEP),
    .OUT_PERIODIC (P_PERIODIC),
    .OUT_LAYER    (P_LAYER)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .new_input   (new_input),
    .q_push      (q_push),
    .q_push_valid(q_push_valid),
    .q_pop       (q_pop),
    .q_pop_valid (q_pop_valid),
    .pacing      (pacing),
    .slide       (slide),
    .busy        (busy),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  typedef struct { int k; logic acc; } push_t;
  typedef struct { int k; logic [2:0] ent; } pop_t;

  push_t exp_push [$];
  pop_t  exp_pop  [$];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at t=%0t: actual=%0h required=%0h", name, $time, act, req);
    end
  endtask

  function automatic logic [7:0] ref_pacing(input logic [2:0] ent, input int lay);
    logic [7:0] r;
    r = '0;
    for (int o = 0; o < 8; o++) begin
      if (layer_of[o] == lay &&
          ((ent[0] && by_in0[o]) || (ent[1] && by_in1[o]) || (ent[2] && by_tick[o])))
        r[o] = 1'b1;
    end
    return r;
  endfunction

  // ---------------- reference model (stimulus side) ----------------
  int         k = 0;        // enabled-cycle index since reset
  int         free_at = 0;  // first enabled cycle in which the scheduler can start
  logic [2:0] mq [$];

  task automatic model_cycle(input logic [1:0] ni);
    logic       tk, rq, popped, byp, acc;
    logic [2:0] entry, ent;
    tk     = ((k % PERIOD) == PERIOD - 1);
    rq     = (ni != 0) || tk;
    entry  = {tk, ni};
    popped = 1'b0;
    byp    = 1'b0;
    if (k >= free_at && mq.size() > 0) begin
      ent = mq.pop_front();
      exp_pop.push_back('{k, ent});
      free_at = k + NL + 1;
      popped = 1'b1;
    end
`ifdef EVAL_SCHED_BYPASS_EN
    byp = rq && !popped && k >= free_at && mq.size() == 0;
`endif
    if (byp) begin
      exp_pop.push_back('{k, entry});
      exp_push.push_back('{k, 1'b1});
      free_at = k + NL + 1;
    end else if (rq) begin
      acc = (mq.size() < DEPTH);
      if (acc) mq.push_back(entry);
      exp_push.push_back('{k, acc});
    end
    k++;
  endtask

  task automatic drive(input logic e, input logic [1:0] ni);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    en        = e;
    new_input = ni;
    if (e) model_cycle(ni);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst       = 1'b1;
    en        = 1'b1;
    new_input = 2'($urandom);
    // Let the monitor consume the last pre-reset sample before clearing.
    @(negedge clk);
    #1;
    exp_push.delete();
    exp_pop.delete();
    mq.delete();
    k = 0;
    free_at = 0;
  endtask

  // ---------------- monitor ----------------
  logic       rst_d = 1'b1;
  logic       en_d = 1'b0;
  int         mk = 0;
  logic       act = 1'b0;
  int         lay = 0;
  logic [2:0] ment = '0;
  logic       m_ovf = 1'b0;
  logic [7:0] last_pac = '0;
  logic [1:0] last_sl = '0;
  logic       last_busy = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst_d) begin
        chk("reset_outputs", 32'({q_push, q_push_valid, q_pop, q_pop_valid, pacing, slide, busy, overflow}), 32'd0);
        mk = 0; act = 1'b0; lay = 0; m_ovf = 1'b0;
        last_pac = '0; last_sl = '0; last_busy = 1'b0;
      end else if (!en_d) begin
        chk("hold_q_push", 32'(q_push), 32'd0);
        chk("hold_q_pop", 32'(q_pop), 32'd0);
        chk("hold_pacing", 32'(pacing), 32'(last_pac));
        chk("hold_slide", 32'(slide), 32'(last_sl));
        chk("hold_busy", 32'(busy), 32'(last_busy));
        chk("hold_overflow", 32'(overflow), 32'(m_ovf));
      end else begin
        logic       push_here, pop_here;
        logic [7:0] e_pac;
        logic [1:0] e_sl;
        push_t      pr;
        pop_t       pp;
        while (exp_push.size() > 0 && exp_push[0].k < mk) begin
          pr = exp_push.pop_front();
          checks++; failures++;
          $display("FAIL push_lost cycle=%0d: actual=none required=push", pr.k);
        end
        while (exp_pop.size() > 0 && exp_pop[0].k < mk) begin
          pp = exp_pop.pop_front();
          checks++; failures++;
          $display("FAIL pop_lost cycle=%0d: actual=none required=pop", pp.k);
        end
        push_here = (exp_push.size() > 0 && exp_push[0].k == mk);
        pop_here  = (exp_pop.size() > 0 && exp_pop[0].k == mk);
        chk("q_push", 32'(q_push), 32'(push_here));
        if (push_here) begin
          pr = exp_push.pop_front();
          if (q_push) chk("q_push_valid", 32'(q_push_valid), 32'(pr.acc));
          if (!pr.acc) m_ovf = 1'b1;
        end
        chk("q_pop", 32'(q_pop), 32'(pop_here));
        chk("q_pop_valid", 32'(q_pop_valid), 32'(pop_here));
        if (pop_here) begin
          pp   = exp_pop.pop_front();
          act  = 1'b1;
          lay  = 0;
          ment = pp.ent;
        end else if (act) begin
          lay++;
          if (lay >= NL) act = 1'b0;
        end
        e_pac = act ? ref_pacing(ment, lay) : 8'h00;
        e_sl  = (act && lay == 0 && ment[2]) ? 2'b11 : 2'b00;
        chk("pacing", 32'(pacing), 32'(e_pac));
        chk("slide", 32'(slide), 32'(e_sl));
        chk("busy", 32'(busy), 32'(act));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        last_pac  = e_pac;
        last_sl   = e_sl;
        last_busy = act;
        mk++;
      end
      rst_d = rst;
      en_d  = en;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic       e;
    logic [1:0] ni;
    int         thr;
    repeat (3) @(posedge clk);

    // Idle until past the first periodic tick.
    repeat (505) drive(1'b1, 2'b00);

    // Single event on input 0.
    drive(1'b1, 2'b01);
    repeat (6) drive(1'b1, 2'b00);

    // Three back-to-back events, reset during layer 1 of the first.
    repeat (3) drive(1'b1, 2'b01);
    do_reset();
    repeat (10) drive(1'b1, 2'b00);

    // Event coincident with a tick.
    while (k != PERIOD - 1) drive(1'b1, 2'b00);
    drive(1'b1, 2'b10);
    repeat (6) drive(1'b1, 2'b00);

    // Sustained input to overflow the queue.
    repeat (10) drive(1'b1, 2'b01);
    repeat (20) drive(1'b1, 2'b00);

    // Randomised traffic with enable gaps and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        thr = (n / 400) % 3;
        e   = ($urandom_range(0, 9) != 0);
        case (thr)
          0:       ni = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00;
          1:       ni = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
          default: ni = ($urandom_range(0, 3) != 0) ? 2'($urandom) : 2'b00;
        endcase
        if ((k % PERIOD) == PERIOD - 1 && $urandom_range(0, 1) == 1) ni = 2'b11;
        drive(e, ni);
      end
    end

    repeat (25) drive(1'b1, 2'b00);
    @(negedge clk);
    #1;
    chk("drain_push_queue", 32'(exp_push.size()), 32'd0);
    chk("drain_pop_queue", 32'(exp_pop.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
